led_cal_ctrl: RTL

- Parametrised multi-channel LED front-end calibration controller for the optical sensing path.
- On a start request, for each LED channel in turn:
  - finds the DC-compensation code by successive approximation over ADC min/max windows;
  - then finds the highest non-clipping PGA gain.
- After calibration, time-multiplexes the LEDs with the stored per-channel settings and captures one ADC value per channel per dwell.

---
 rtl/led_cal_ctrl.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/led_cal_ctrl.sv
// LED front-end calibration: per-channel DC SAR, PGA gain search, then LED time-multiplexing.
// Optional build macro RUN_AVG_EN: RUN capture is the dwell mean instead of the last sample.
module led_cal_ctrl #(
   parameter int NCH     = 2,
   parameter int ADC_W   = 8,
   parameter int DC_W    = 7,
   parameter int PGA_W   = 4,
   parameter int WIN_LEN = 1000,
   parameter int SETTLE  = 4,
   parameter int DWELL   = 8,
   parameter int MID_LO  = 120,
   parameter int MID_HI  = 135,
   parameter int CLIP_LO = 10,
   parameter int CLIP_HI = 245
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADC_W-1:0]     adc_data,
   input  logic                 adc_valid,
   output logic [NCH-1:0]       led_en,
   output logic [DC_W-1:0]      dc_comp,
   output logic [PGA_W-1:0]     pga_gain,
   output logic                 busy,
   output logic                 cal_done,
   output logic [NCH*ADC_W-1:0] ch_value,
   output logic                 value_valid,
   output logic [2:0]           value_ch
);
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int BIT_W = (DC_W > 1) ? $clog2(DC_W) : 1;
   localparam int M1    = (WIN_LEN > SETTLE) ? WIN_LEN : SETTLE;
   localparam int M2    = (M1 > DWELL) ? M1 : DWELL;
   localparam int CNT_W = (M2 > 1) ? $clog2(M2) : 1;
   localparam logic [DC_W-1:0] DC_MSB = {1'b1, {(DC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, SETTLE_W, DC_SRCH, PGA_SRCH, NEXT_CH, RUN
   } state_t;

   state_t            state_q, state_d;
   state_t            pend_q, pend_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [DC_W-1:0]   dc_q, dc_d;
   logic [PGA_W-1:0]  gain_q, gain_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADC_W-1:0]  min_q, min_d;
   logic [ADC_W-1:0]  max_q, max_d;
   logic              vv_q, vv_d;
   logic [2:0]        vch_q, vch_d;
   logic [NCH*ADC_W-1:0] val_q;
   logic [DC_W-1:0]   dc_tab_q [NCH];
   logic [PGA_W-1:0]  gain_tab_q [NCH];

   logic              dc_we, gain_we, cap_we;
   logic [PGA_W-1:0]  gain_wv;
   logic [ADC_W-1:0]  cap_v;
   logic [ADC_W-1:0]  win_min, win_max;
   logic [ADC_W:0]    mid;
   logic              in_band, below, clip, win_end, dwell_end;

   // window statistics include the sample arriving this cycle
   assign win_min   = (adc_data < min_q) ? adc_data : min_q;
   assign win_max   = (adc_data > max_q) ? adc_data : max_q;
   assign mid       = ({1'b0, win_max} + {1'b0, win_min}) >> 1;
   assign below     = mid < (ADC_W+1)'(MID_LO);
   assign in_band   = !below && (mid <= (ADC_W+1)'(MID_HI));
   assign clip      = (win_min <= ADC_W'(CLIP_LO)) ||
                      (win_max >= ADC_W'(CLIP_HI));
   assign win_end   = cnt_q == CNT_W'(WIN_LEN-1);
   assign dwell_end = cnt_q == CNT_W'(DWELL-1);

`ifdef RUN_AVG_EN
   localparam int DW_LOG = (DWELL > 1) ? $clog2(DWELL) : 0;
   localparam int SUM_W  = ADC_W + DW_LOG;
   logic [SUM_W-1:0] sum_q, sum_d, sum_in;

   assign sum_in = sum_q + SUM_W'(adc_data);
   assign cap_v  = sum_in[DW_LOG +: ADC_W];

   always_comb begin
      sum_d = sum_q;
      if (start || state_q != RUN) begin
         sum_d = '0;
      end else if (adc_valid) begin
         sum_d = dwell_end ? '0 : sum_in;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`else
   assign cap_v = adc_data;
`endif

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      ch_d    = ch_q;
      dc_d    = dc_q;
      gain_d  = gain_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      min_d   = min_q;
      max_d   = max_q;
      vv_d    = 1'b0;
      vch_d   = vch_q;
      dc_we   = 1'b0;
      gain_we = 1'b0;
      gain_wv = gain_q;
      cap_we  = 1'b0;
      if (start) begin
         state_d = SETTLE_W;
         pend_d  = DC_SRCH;
         ch_d    = '0;
         dc_d    = DC_MSB;
         gain_d  = '0;
         bit_d   = BIT_W'(DC_W-1);
         cnt_d   = '0;
         min_d   = '1;
         max_d   = '0;
      end else begin
         unique case (state_q)
            SETTLE_W: begin
               if (adc_valid) begin
                  if (cnt_q == CNT_W'(SETTLE-1)) begin
                     state_d = pend_q;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            DC_SRCH: begin
               if (adc_valid) begin
                  min_d = win_min;
                  max_d = win_max;
                  cnt_d = cnt_q + 1'b1;
                  if (win_end) begin
                     cnt_d   = '0;
                     min_d   = '1;
                     max_d   = '0;
                     state_d = SETTLE_W;
                     if (below) begin
                        dc_d[bit_q] = 1'b0;
                     end
                     if (in_band || bit_q == '0) begin
                        dc_we  = 1'b1;
                        gain_d = '0;
                        pend_d = PGA_SRCH;
                     end else begin
                        dc_d[bit_q - 1'b1] = 1'b1;
                        bit_d = bit_q - 1'b1;
                     end
                  end
               end
            end
            PGA_SRCH: begin
               if (adc_valid) begin
                  min_d = win_min;
                  max_d = win_max;
                  cnt_d = cnt_q + 1'b1;
                  if (win_end) begin
                     cnt_d = '0;
                     min_d = '1;
                     max_d = '0;
                     if (!clip && gain_q != '1) begin
                        gain_d  = gain_q + 1'b1;
                        state_d = SETTLE_W;
                     end else begin
                        gain_we = 1'b1;
                        state_d = NEXT_CH;
                        if (clip) begin
                           gain_wv = (gain_q == '0) ? '0 : gain_q - 1'b1;
                        end
                     end
                  end
               end
            end
            NEXT_CH: begin
               cnt_d = '0;
               if (ch_q != CH_W'(NCH-1)) begin
                  ch_d    = ch_q + 1'b1;
                  dc_d    = DC_MSB;
                  gain_d  = '0;
                  bit_d   = BIT_W'(DC_W-1);
                  pend_d  = DC_SRCH;
                  state_d = SETTLE_W;
               end else begin
                  ch_d    = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (adc_valid) begin
                  if (dwell_end) begin
                     cnt_d  = '0;
                     cap_we = 1'b1;
                     vv_d   = 1'b1;
                     vch_d  = 3'(ch_q);
                     ch_d   = (ch_q == CH_W'(NCH-1)) ? '0 : ch_q + 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= DC_SRCH;
         ch_q    <= '0;
         dc_q    <= '0;
         gain_q  <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         min_q   <= '1;
         max_q   <= '0;
         vv_q    <= 1'b0;
         vch_q   <= '0;
         val_q   <= '0;
         for (int k = 0; k < NCH; k++) begin
            dc_tab_q[k]   <= '0;
            gain_tab_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ch_q    <= ch_d;
         dc_q    <= dc_d;
         gain_q  <= gain_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         min_q   <= min_d;
         max_q   <= max_d;
         vv_q    <= vv_d;
         vch_q   <= vch_d;
         if (dc_we) begin
            dc_tab_q[ch_q] <= dc_d;
         end
         if (gain_we) begin
            gain_tab_q[ch_q] <= gain_wv;
         end
         if (cap_we) begin
            val_q[ch_q*ADC_W +: ADC_W] <= cap_v;
         end
      end
   end

   // RUN drives the AFE from the tables so settings follow the LED without delay
   always_comb begin
      led_en = '0;
      if (state_q != IDLE) begin
         led_en[ch_q] = 1'b1;
      end
   end

   assign dc_comp     = (state_q == RUN) ? dc_tab_q[ch_q] : dc_q;
   assign pga_gain    = (state_q == RUN) ? gain_tab_q[ch_q] : gain_q;
   assign busy        = state_q inside {SETTLE_W, DC_SRCH, PGA_SRCH, NEXT_CH};
   assign cal_done    = state_q == RUN;
   assign ch_value    = val_q;
   assign value_valid = vv_q;
   assign value_ch    = vch_q;

endmodule
